sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_pkg.sv | 18 +
 rtl/sram_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared constants and power-state encoding for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  localparam int FIFO_AW = 9;
  localparam int FIFO_DW = 64;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  localparam int FIFO_DEPTH = fifo_depth(FIFO_AW);

  typedef enum logic {
    PWR_ACTIVE = 1'b0,
    PWR_SLEEP  = 1'b1
  } pwr_state_t;

endpackage

// File: rtl/sram_fifo_ctrl.sv
// Show-ahead FIFO controller around an external dual-port SRAM (port A read, port B write).
// The SRAM read register doubles as the output stage; deep sleep is entered only when empty.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int AW = FIFO_AW,
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  input  logic          flush,
  input  logic          sleep_req,
  output logic [AW+1:0] level,
  output logic          ram_clkA,
  output logic          ram_clkB,
  output logic          ram_cenA,
  output logic          ram_cenB,
  output logic [AW-1:0] ram_aA,
  output logic [AW-1:0] ram_aB,
  output logic [DW-1:0] ram_d,
  output logic [DW-1:0] ram_bw,
  output logic          ram_deepsleep,
  output logic          ram_powergate,
  input  logic [DW-1:0] ram_q
);

  localparam int DEPTH = fifo_depth(AW);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;
  logic          out_valid;
  pwr_state_t    state;
  logic          push;
  logic          fetch;
  logic          pop;

  assign ram_deepsleep = (state == PWR_SLEEP);
  assign ram_powergate = 1'b0;

  // rst gates both strobes so the RAM enables go inactive the moment reset asserts
  assign wr_ready = !rst && (ram_cnt < FULL_CNT) && !flush && !ram_deepsleep;
  assign push     = wr_valid && wr_ready;
  assign fetch    = !rst && (ram_cnt != '0) && (!out_valid || rd_ready)
                    && !flush && !ram_deepsleep;
  assign pop      = out_valid && rd_ready;

  assign ram_clkA = clk;
  assign ram_clkB = clk;
  assign ram_cenA = !fetch;
  assign ram_aA   = rd_ptr;
  assign ram_cenB = !push;
  assign ram_aB   = wr_ptr;
  assign ram_d    = wr_data;
  assign ram_bw   = push ? {DW{1'b1}} : {DW{1'b0}};

  // ram_q holds while port A is idle, so it serves directly as the show-ahead output
  assign rd_valid = out_valid;
  assign rd_data  = ram_q;
  assign level    = {1'b0, ram_cnt} + {{(AW+1){1'b0}}, out_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, fetch})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      if (fetch) out_valid <= 1'b1;
      else if (pop) out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PWR_ACTIVE;
    end else begin
      case (state)
        PWR_ACTIVE: if (sleep_req && level == '0 && !wr_valid) state <= PWR_SLEEP;
        PWR_SLEEP:  if (!sleep_req) state <= PWR_ACTIVE;
        default:    state <= PWR_ACTIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl with a behavioural dual-port SRAM and a queue reference model.
module tb_sram_fifo_ctrl;
  localparam int AW = 9;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, flush, sleep_req;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW+1:0] level;
  logic          ram_clkA, ram_clkB, ram_cenA, ram_cenB, ram_deepsleep, ram_powergate;
  logic [AW-1:0] ram_aA, ram_aB;
  logic [DW-1:0] ram_d, ram_bw, ram_q;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .flush(flush), .sleep_req(sleep_req), .level(level),
    .ram_clkA(ram_clkA), .ram_clkB(ram_clkB),
    .ram_cenA(ram_cenA), .ram_cenB(ram_cenB),
    .ram_aA(ram_aA), .ram_aB(ram_aB), .ram_d(ram_d), .ram_bw(ram_bw),
    .ram_deepsleep(ram_deepsleep), .ram_powergate(ram_powergate),
    .ram_q(ram_q)
  );

  // behavioural SRAM: synchronous write on B with bit mask, registered read on A
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] q_reg = '0;
  assign ram_q = q_reg;
  always @(posedge clk) begin
    if (!ram_cenB) mem[ram_aB] <= (mem[ram_aB] & ~ram_bw) | (ram_d & ram_bw);
    if (!ram_cenA) q_reg <= mem[ram_aA];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: ordered list of held words plus expected RAM address sequences
  logic [DW-1:0] model_q[$];
  int            waddr = 0;
  int            raddr = 0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
      waddr = 0;
      raddr = 0;
      hold_prev = 1'b0;
    end else begin
      chk("level", level, model_q.size());
      chk("powergate", ram_powergate, 0);
      if (rd_valid) chk("rd_valid_has_data", model_q.size() > 0, 1);
      if (hold_prev) begin
        chk("hold_valid", rd_valid, 1);
        chk("hold_data", rd_data, hold_data);
      end
      if (flush) begin
        chk("flush_no_push", wr_ready, 0);
        chk("flush_no_fetch", ram_cenA, 1);
        model_q.delete();
        waddr = 0;
        raddr = 0;
        hold_prev = 1'b0;
      end else begin
        if (rd_valid && rd_ready && model_q.size() > 0) begin
          logic [DW-1:0] e;
          e = model_q.pop_front();
          chk("pop_data", rd_data, e);
        end
        if (!ram_cenA) begin
          chk("rd_addr", ram_aA, raddr % (1 << AW));
          raddr++;
        end
        chk("cenB", ram_cenB, !(wr_valid && wr_ready));
        if (wr_valid && wr_ready) begin
          chk("wr_addr", ram_aB, waddr % (1 << AW));
          chk("bw_ones", ram_bw, {DW{1'b1}});
          model_q.push_back(wr_data);
          waddr++;
        end else if (ram_bw !== '0) begin
          chk("bw_zero", ram_bw, 0);
        end
        hold_prev = rd_valid && !rd_ready;
        hold_data = rd_data;
      end
    end
  end

  initial begin
    int n, pops, lvl_ref, lvl_bad;
    logic seen;
    rst = 1; wr_valid = 0; rd_ready = 0; flush = 0; sleep_req = 0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_cenA", ram_cenA, 1);
    chk("rst_cenB", ram_cenB, 1);
    chk("rst_level", level, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("idle_wr_ready", wr_ready, 1);
    chk("idle_deepsleep", ram_deepsleep, 0);

    // single word latency: pushed at t0, visible at t0+2
    tick(); wr_valid = 1; wr_data = {8{8'hA5}};
    tick(); wr_valid = 0;
    @(negedge clk);
    chk("lat_t1_rd_valid", rd_valid, 0);
    chk("lat_t1_level", level, 1);
    tick();
    @(negedge clk);
    chk("lat_t2_rd_valid", rd_valid, 1);
    chk("lat_t2_rd_data", rd_data, {8{8'hA5}});
    chk("lat_t2_level", level, 1);
    tick(); rd_ready = 1;
    tick(); rd_ready = 0;

    // fill from a clean pointer state with no consumer
    flush = 1; tick(); flush = 0;
    n = 0; wr_valid = 1;
    for (int i = 0; i < 530; i++) begin
      wr_data = rnd();
      @(negedge clk);
      if (wr_ready) begin
        if (n == 512) chk("wrap_wr_addr", ram_aB, 0);
        n++;
      end
      tick();
    end
    wr_valid = 0;
    @(negedge clk);
    chk("full_accepted", n, 513);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_level", level, 513);

    // sustained push and pop from full
    tick(); wr_valid = 1; rd_ready = 1;
    pops = 0; lvl_ref = 0; lvl_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      wr_data = rnd();
      @(negedge clk);
      if (rd_valid) pops++;
      if (i == 4) lvl_ref = int'(level);
      else if (i > 4 && int'(level) != lvl_ref) lvl_bad++;
      tick();
    end
    wr_valid = 0; rd_ready = 0;
    chk("stream_pops", pops, 1000);
    chk("stream_level_ref", lvl_ref, 512);
    chk("stream_level_changes", lvl_bad, 0);

    // flush with stored entries
    flush = 1; tick(); flush = 0;
    wr_valid = 1;
    for (int i = 0; i < 10; i++) begin
      wr_data = rnd();
      tick();
    end
    wr_valid = 0;
    @(negedge clk);
    chk("preflush_level", level, 10);
    tick(); flush = 1;
    tick(); flush = 0;
    @(negedge clk);
    chk("postflush_level", level, 0);
    chk("postflush_rd_valid", rd_valid, 0);
    tick(); wr_valid = 1; wr_data = 64'h1;
    tick(); wr_valid = 0; rd_ready = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rd_valid) begin
        chk("flush_first_word", rd_data, 64'h1);
        seen = 1;
      end
      tick();
    end
    chk("flush_first_seen", seen, 1);
    rd_ready = 0;

    // randomized traffic with occasional flush
    for (int i = 0; i < 4000; i++) begin
      if ((i / 500) % 2 == 0) begin
        wr_valid = $urandom_range(0, 3) != 0;
        rd_ready = $urandom_range(0, 3) == 0;
      end else begin
        wr_valid = $urandom_range(0, 3) == 0;
        rd_ready = $urandom_range(0, 3) != 0;
      end
      flush = $urandom_range(0, 199) == 0;
      if (flush) rd_ready = 0;
      wr_data = rnd();
      tick();
    end
    flush = 0; wr_valid = 0; rd_ready = 1;

    // drain, then deep sleep
    seen = 0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      @(negedge clk);
      if (level == 0) seen = 1;
      else tick();
    end
    chk("drain_done", seen, 1);
    tick(); rd_ready = 0; sleep_req = 1;
    tick();
    @(negedge clk);
    chk("sleep_deepsleep", ram_deepsleep, 1);
    chk("sleep_wr_ready", wr_ready, 0);
    tick(); wr_valid = 1; wr_data = rnd();
    @(negedge clk);
    chk("sleep_blocks_push", wr_ready, 0);
    tick(); wr_valid = 0; sleep_req = 0;
    tick();
    @(negedge clk);
    chk("wake_wr_ready", wr_ready, 1);
    chk("wake_deepsleep", ram_deepsleep, 0);

    // asynchronous reset in the middle of a stream
    tick(); wr_valid = 1;
    for (int i = 0; i < 5; i++) begin
      wr_data = rnd();
      tick();
    end
    rd_ready = 1;
    @(negedge clk);
    chk("prerst_rd_valid", rd_valid, 1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rd_valid", rd_valid, 0);
    chk("async_cenA", ram_cenA, 1);
    chk("async_cenB", ram_cenB, 1);
    chk("async_level", level, 0);
    wr_valid = 0; rd_ready = 0;
    tick(); rst = 0;
    wr_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wr_data = rnd();
      tick();
    end
    wr_valid = 0; rd_ready = 1;
    repeat (6) tick();
    @(negedge clk);
    chk("postrst_drained", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
